shift_deserializer: RTL and testbench
=====================================

# shift_deserializer

Serial-to-parallel receiver for the MSB-first bit stream produced by the shift-register serializer. It collects the first TO bits of each contiguous `valid_i` burst into a parallel word and discards any trailing pad bits in that burst. Each completed word goes to a one-entry output register with a valid/ready handshake. The serial side has no backpressure, so short bursts and output overruns are reported on single-cycle error pulses.

## Interface
- `TO`, default 16: parallel word width in bits; must be at least 2.
- `LOG2TO`, default 4: equals ceil(log2(TO)); bit counter width is LOG2TO+1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_i`  in  1  serial data bit, MSB of the word first.
- `valid_i`  in  1  `data_i` carries a valid bit this cycle; one burst frames one word.
- `data_o`  out  TO  received word; first serial bit is at `data_o[TO-1]`.
- `valid_o`  out  1  `data_o` holds an unconsumed word.
- `ready_i`  in  1  downstream accepts `data_o` when high together with `valid_o`.
- `err_short_o`  out  1  one-cycle pulse: burst ended before TO bits; partial word dropped.
- `err_ovf_o`  out  1  one-cycle pulse: word completed while the output register was full; new word dropped.

## Operation
- Shift register `Reg`, TO bits wide. On an accepted bit, `Reg` becomes `{Reg[TO-2:0], data_i}`.
- Bit counter `Cnt` is LOG2TO+1 bits wide and counts the bits captured so far in the current burst.
- FSM states:
  - IDLE.
    - `valid_i=1`: capture the bit, set Cnt=1, go to SHIFT.
    - `valid_i=0`: no state change.
  - SHIFT.
    - `valid_i=1` and Cnt<TO-1: capture the bit, Cnt+1.
    - `valid_i=1` and Cnt==TO-1: capture the TO-th bit, the word is complete, go to DRAIN.
    - `valid_i=0`: pulse `err_short_o`, clear Cnt, go to IDLE.
  - DRAIN.
    - `valid_i=1`: discard the bit (pad).
    - `valid_i=0`: go to IDLE.
- Word completion, with full word W = `{Reg[TO-2:0], data_i}`:
  - If `valid_o=0` or `ready_i=1`: load `data_o` with W and set `valid_o=1`.
  - Otherwise: keep `data_o` unchanged and pulse `err_ovf_o`.
- Handshake:
  - When `valid_o` and `ready_i` are both high, the word is consumed. `valid_o` clears next cycle unless a completion in the same cycle reloads it.
  - `data_o` is stable while `valid_o=1` and `ready_i=0`.
- Framing:
  - Bursts must be separated by at least one cycle with `valid_i=0`.
  - Bits after the TO-th bit of a burst are always discarded. A back-to-back second word with no gap is treated as pad.
  - A burst of exactly TO bits is legal: DRAIN exits on the first low cycle.
- Reset:
  - Clears `Reg`, `Cnt`, `data_o`, `valid_o`, `err_short_o` and `err_ovf_o` to 0.
  - The FSM resets to DRAIN, so a burst already in flight when reset is released is ignored, not misaligned.
  - Asserting reset mid-burst or mid-handshake discards all held data with no error pulse.
- The error outputs are registered and never both high in the same cycle.

## Timing
- Latency: the TO-th bit is sampled at edge k, and `valid_o=1` with the word on `data_o` from cycle k+1.
- Paired with the serializer, where a load at cycle 0 emits bits during cycles 0..TO with the last bit being a pad 0: the word appears at cycle TO, and the pad bit is dropped in DRAIN.
- Error pulses go high in the cycle after the triggering event and last exactly one cycle.
- Throughput: one word per TO+1 cycles at best (TO bits plus the one-cycle gap). Always accepting serial input needs no stall.
- The completion-vs-consume collision (completion while `valid_o=1` and `ready_i=1`) loads the new word with no bubble and no `err_ovf_o`.

## Test plan
- **Basic word, TO=16.** Stimulus: burst of 17 bits, the 16 bits of 0xA5C3 MSB first plus a pad 0, then `valid_i=0`; `ready_i=1`. Required: `data_o=0xA5C3`, `valid_o` high for exactly one cycle, beginning one cycle after the 16th bit; no error pulses.
- **Short burst.** Stimulus: 9 bits, then `valid_i` low. Required: `err_short_o` pulses once, `valid_o` stays 0. Then a full burst of 0x0001 is received correctly.
- **Overflow.** Stimulus: `ready_i=0`, two bursts 0x1234 and 0xBEEF. Required: `data_o` stays 0x1234, `err_ovf_o` pulses once. Then `ready_i=1` consumes 0x1234 and `valid_o` drops.
- **Consume-and-load collision.** Stimulus: `ready_i` held 0 with 0x1111 pending; raise `ready_i` in exactly the cycle the 16th bit of 0x2222 arrives. Required: next cycle `data_o=0x2222`, `valid_o=1`, no `err_ovf_o`.
- **Reset behaviour.** Stimulus: `valid_i` held high across reset release, followed by 10 more bits, then a gap, then 0xFFFF. Required: all outputs are 0 during reset; no word and no error for the in-flight burst; 0xFFFF is delivered.
- **Exact-length bursts.** Stimulus: back-to-back 16-bit bursts 0x8000 and 0x0001, each followed by a one-cycle gap. Required: both words are delivered, 17 cycles apart.

Source files
------------

// File: rtl/shift_deserializer.sv
// MSB-first serial-to-parallel receiver with a one-entry valid/ready output
// register; short bursts and output overruns raise one-cycle error pulses.
module shift_deserializer #(
   parameter int TO     = 16,
   parameter int LOG2TO = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          data_i,
   input  logic          valid_i,
   output logic [TO-1:0] data_o,
   output logic          valid_o,
   input  logic          ready_i,
   output logic          err_short_o,
   output logic          err_ovf_o
);

   localparam int CW = LOG2TO + 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DRAIN
   } state_t;

   state_t          state_q;
   logic [TO-1:0]   reg_q;
   logic [CW-1:0]   cnt_q;
   logic [TO-1:0]   data_q;
   logic            valid_q;
   logic            err_short_q;
   logic            err_ovf_q;
   logic [TO-1:0]   word_d;
   logic            last_d;

   assign word_d = {reg_q[TO-2:0], data_i};
   assign last_d = (cnt_q == CW'(TO - 1));

   // Starting in DRAIN keeps a burst already in flight at reset release
   // from being taken as the head of a word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= DRAIN;
         reg_q       <= '0;
         cnt_q       <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         err_short_q <= 1'b0;
         err_ovf_q   <= 1'b0;
      end else begin
         err_short_q <= 1'b0;
         err_ovf_q   <= 1'b0;
         if (valid_q && ready_i) begin
            valid_q <= 1'b0;
         end
         unique case (state_q)
            IDLE: begin
               if (valid_i) begin
                  reg_q   <= word_d;
                  cnt_q   <= CW'(1);
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (valid_i) begin
                  reg_q <= word_d;
                  cnt_q <= cnt_q + CW'(1);
                  if (last_d) begin
                     state_q <= DRAIN;
                     if (!valid_q || ready_i) begin
                        data_q  <= word_d;
                        valid_q <= 1'b1;
                     end else begin
                        err_ovf_q <= 1'b1;
                     end
                  end
               end else begin
                  err_short_q <= 1'b1;
                  cnt_q       <= '0;
                  state_q     <= IDLE;
               end
            end
            DRAIN: begin
               if (!valid_i) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= DRAIN;
         endcase
      end
   end

   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign err_short_o = err_short_q;
   assign err_ovf_o   = err_ovf_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Directed self-checking bench for shift_deserializer (TO=16).
// Inputs change 1ns after each rising edge; outputs are read there too.
module tb_shift_deserializer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        data_i = 1'b0;
   logic        valid_i = 1'b0;
   logic [15:0] data_o;
   logic        valid_o;
   logic        ready_i = 1'b1;
   logic        err_short_o;
   logic        err_ovf_o;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   int n_short = 0;
   int n_ovf = 0;
   int n_both = 0;

   shift_deserializer #(.TO(16), .LOG2TO(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .data_i      (data_i),
      .valid_i     (valid_i),
      .data_o      (data_o),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .err_short_o (err_short_o),
      .err_ovf_o   (err_ovf_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (err_short_o) n_short++;
      if (err_ovf_o) n_ovf++;
      if (err_short_o && err_ovf_o) n_both++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [15:0] w);
      for (int i = 15; i >= 0; i--) begin
         data_i  = w[i];
         valid_i = 1'b1;
         step();
      end
   endtask

   task automatic gap();
      valid_i = 1'b0;
      data_i  = 1'b0;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      n_chk++;
      if ({data_o, valid_o, err_short_o, err_ovf_o} !== 19'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got data=%h v=%b es=%b eo=%b want all 0",
                  data_o, valid_o, err_short_o, err_ovf_o);
      end
      reset = 1'b0;
      gap();
   endtask

   task automatic test_basic();
      int s0 = n_short;
      int o0 = n_ovf;
      ready_i = 1'b1;
      send_word(16'hA5C3);
      n_chk++;
      if (valid_o !== 1'b1 || data_o !== 16'hA5C3) begin
         n_fail++;
         $display("FAIL basic_word: got v=%b data=%h want v=1 data=a5c3",
                  valid_o, data_o);
      end
      data_i = 1'b0;
      step();
      n_chk++;
      if (valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_one_cycle: got v=%b want 0", valid_o);
      end
      gap();
      gap();
      n_chk++;
      if (n_short != s0 || n_ovf != o0 || valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_no_err: got short=%0d ovf=%0d v=%b want 0 0 0",
                  n_short - s0, n_ovf - o0, valid_o);
      end
   endtask

   task automatic test_short();
      int s0 = n_short;
      ready_i = 1'b1;
      for (int i = 0; i < 9; i++) begin
         data_i  = i[0];
         valid_i = 1'b1;
         step();
      end
      gap();
      n_chk++;
      if (err_short_o !== 1'b1 || valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL short_pulse: got es=%b v=%b want es=1 v=0",
                  err_short_o, valid_o);
      end
      gap();
      n_chk++;
      if (err_short_o !== 1'b0 || n_short - s0 != 1) begin
         n_fail++;
         $display("FAIL short_once: got es=%b pulses=%0d want 0 and 1",
                  err_short_o, n_short - s0);
      end
      send_word(16'h0001);
      n_chk++;
      if (valid_o !== 1'b1 || data_o !== 16'h0001) begin
         n_fail++;
         $display("FAIL short_recover: got v=%b data=%h want v=1 data=0001",
                  valid_o, data_o);
      end
      gap();
      gap();
   endtask

   task automatic test_overflow();
      int o0 = n_ovf;
      ready_i = 1'b0;
      send_word(16'h1234);
      gap();
      n_chk++;
      if (valid_o !== 1'b1 || data_o !== 16'h1234) begin
         n_fail++;
         $display("FAIL ovf_first: got v=%b data=%h want v=1 data=1234",
                  valid_o, data_o);
      end
      send_word(16'hBEEF);
      n_chk++;
      if (err_ovf_o !== 1'b1 || data_o !== 16'h1234 || valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_pulse: got eo=%b v=%b data=%h want 1 1 1234",
                  err_ovf_o, valid_o, data_o);
      end
      gap();
      n_chk++;
      if (err_ovf_o !== 1'b0 || n_ovf - o0 != 1 || data_o !== 16'h1234) begin
         n_fail++;
         $display("FAIL ovf_once: got eo=%b pulses=%0d data=%h want 0 1 1234",
                  err_ovf_o, n_ovf - o0, data_o);
      end
      ready_i = 1'b1;
      step();
      n_chk++;
      if (valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_drain: got v=%b want 0", valid_o);
      end
   endtask

   task automatic test_collision();
      int o0 = n_ovf;
      ready_i = 1'b0;
      send_word(16'h1111);
      gap();
      for (int i = 15; i >= 0; i--) begin
         data_i  = i[1];
         data_i  = (i == 13 || i == 9 || i == 5 || i == 1);
         valid_i = 1'b1;
         if (i == 0) ready_i = 1'b1;
         step();
      end
      n_chk++;
      if (valid_o !== 1'b1 || data_o !== 16'h2222 || err_ovf_o !== 1'b0) begin
         n_fail++;
         $display("FAIL collision: got v=%b data=%h eo=%b want 1 2222 0",
                  valid_o, data_o, err_ovf_o);
      end
      gap();
      n_chk++;
      if (valid_o !== 1'b0 || n_ovf != o0) begin
         n_fail++;
         $display("FAIL collision_after: got v=%b ovf=%0d want 0 0",
                  valid_o, n_ovf - o0);
      end
   endtask

   task automatic test_reset_inflight();
      int s0;
      int o0;
      int bad = 0;
      ready_i = 1'b0;
      send_word(16'h5555);
      gap();
      reset   = 1'b1;
      valid_i = 1'b1;
      data_i  = 1'b1;
      repeat (2) step();
      n_chk++;
      if ({data_o, valid_o, err_short_o, err_ovf_o} !== 19'd0) begin
         n_fail++;
         $display("FAIL rst_mid: got data=%h v=%b es=%b eo=%b want all 0",
                  data_o, valid_o, err_short_o, err_ovf_o);
      end
      s0 = n_short;
      o0 = n_ovf;
      ready_i = 1'b1;
      reset   = 1'b0;
      for (int i = 0; i < 11; i++) begin
         data_i = i[0];
         step();
         if (valid_o !== 1'b0) bad++;
      end
      gap();
      gap();
      n_chk++;
      if (bad != 0 || n_short != s0 || n_ovf != o0) begin
         n_fail++;
         $display("FAIL rst_inflight: got words=%0d short=%0d ovf=%0d want 0 0 0",
                  bad, n_short - s0, n_ovf - o0);
      end
      send_word(16'hFFFF);
      n_chk++;
      if (valid_o !== 1'b1 || data_o !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL rst_next: got v=%b data=%h want v=1 data=ffff",
                  valid_o, data_o);
      end
      gap();
   endtask

   task automatic test_back_to_back();
      int t1 = -1;
      int t2 = -1;
      ready_i = 1'b1;
      send_word(16'h8000);
      if (valid_o === 1'b1) t1 = cyc;
      n_chk++;
      if (valid_o !== 1'b1 || data_o !== 16'h8000) begin
         n_fail++;
         $display("FAIL b2b_first: got v=%b data=%h want v=1 data=8000",
                  valid_o, data_o);
      end
      gap();
      send_word(16'h0001);
      if (valid_o === 1'b1) t2 = cyc;
      n_chk++;
      if (valid_o !== 1'b1 || data_o !== 16'h0001) begin
         n_fail++;
         $display("FAIL b2b_second: got v=%b data=%h want v=1 data=0001",
                  valid_o, data_o);
      end
      n_chk++;
      if (t1 < 0 || t2 - t1 != 17) begin
         n_fail++;
         $display("FAIL b2b_spacing: got %0d cycles want 17", t2 - t1);
      end
      gap();
   endtask

   initial begin
      step();
      test_reset();
      test_basic();
      test_short();
      test_overflow();
      test_collision();
      test_reset_inflight();
      test_back_to_back();
      n_chk++;
      if (n_both != 0) begin
         n_fail++;
         $display("FAIL err_exclusive: got %0d overlap cycles want 0", n_both);
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
